// File: rtl/seq_pkg.sv
// seq_pkg: note codes, frequency table, melody entry type, default melody and FSM states
package seq_pkg;
  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] C4 = 4'd1;
  localparam logic [3:0] D4 = 4'd2;
  localparam logic [3:0] E4 = 4'd3;
  localparam logic [3:0] F4 = 4'd4;
  localparam logic [3:0] G4 = 4'd5;
  localparam logic [3:0] A4 = 4'd6;
  localparam logic [3:0] B4 = 4'd7;
  localparam logic [3:0] C5 = 4'd8;
  localparam logic [3:0] D5 = 4'd9;
  localparam logic [3:0] E5 = 4'd10;
  localparam logic [3:0] F5 = 4'd11;
  localparam logic [3:0] G5 = 4'd12;
  localparam int MELODY_LEN = 8;
  typedef struct packed {
    logic [3:0] code;
    logic [7:0] dur;
  } note_t;
  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;
  localparam logic [31:0] FREQ_LUT [12] = '{
    32'd262, 32'd294, 32'd330, 32'd349, 32'd392, 32'd440,
    32'd494, 32'd523, 32'd587, 32'd659, 32'd698, 32'd784
  };
  localparam note_t MELODY [MELODY_LEN] = '{
    '{C4, 8'd4}, '{E4, 8'd4}, '{G4, 8'd4}, '{REST, 8'd2},
    '{C5, 8'd8}, '{G4, 8'd2}, '{E4, 8'd2}, '{C4, 8'd8}
  };
  // Codes outside 1..12 are silent.
  function automatic logic is_rest(input logic [3:0] c);
    return c == 4'd0 || c > 4'd12;
  endfunction
  function automatic logic [31:0] code_freq(input logic [3:0] c);
    return is_rest(c) ? 32'd0 : FREQ_LUT[c - 4'd1];
  endfunction
endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational entry lookup, kept apart so the tune can change without touching the FSM
module melody_rom
  import seq_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic [IW-1:0] idx,
  output note_t         note
);
  assign note = (32'(idx) < MELODY_LEN) ? MELODY[idx] : note_t'{REST, 8'd1};
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps the melody table, timing notes and articulation gaps in tempo ticks
module note_sequencer
  import seq_pkg::*;
#(
  parameter int FCLK = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int GAP_TICKS = 2,
  parameter int NUM_NOTES = 8,
  localparam int IW = NUM_NOTES > 1 ? $clog2(NUM_NOTES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [31:0]   freq,
  output logic          onOff,
  output logic          busy,
  output logic [IW-1:0] note_idx,
  output logic          done
);
  localparam logic [31:0]   TICK_LAST = 32'(FCLK / TICK_HZ - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_TICKS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);
  state_t state, state_n, adv_state;
  logic [31:0] tcnt, freq_n;
  logic [7:0] dcnt, dur_last;
  logic [IW-1:0] idx_n, adv_idx;
  logic on_n, adv, tick, at_last;
  note_t nxt;
  assign tick = tcnt == TICK_LAST;
  assign at_last = note_idx == LAST_IDX;
  assign adv_state = (at_last && !loop) ? DONE : PLAY;
  assign adv_idx = at_last ? '0 : note_idx + IW'(1);
  assign busy = state == PLAY || state == GAP;
  assign done = state == DONE;
  // The entry about to be entered drives the freq/onOff load on the transition edge.
  melody_rom #(.IW(IW)) u_rom (
    .idx (idx_n),
    .note(nxt)
  );
  // Next state, next entry and the registered tone outputs; adv marks any state entry.
  always_comb begin
    state_n = state;
    idx_n = note_idx;
    adv = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = PLAY;
        idx_n = '0;
        adv = 1'b1;
      end
      PLAY: if (tick && dcnt == dur_last) begin
        adv = 1'b1;
        state_n = (GAP_TICKS > 0) ? GAP : adv_state;
        idx_n = (GAP_TICKS > 0) ? note_idx : adv_idx;
      end
      GAP: if (tick && dcnt == GAP_LAST) begin
        adv = 1'b1;
        state_n = adv_state;
        idx_n = adv_idx;
      end
      default: begin
        adv = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (stop) begin
      adv = 1'b1;
      state_n = IDLE;
      idx_n = '0;
    end
    on_n = adv ? (state_n == PLAY && !is_rest(nxt.code)) : onOff;
    freq_n = !adv ? freq
           : (state_n == IDLE || state_n == DONE) ? '0
           : (state_n == PLAY && !is_rest(nxt.code)) ? code_freq(nxt.code)
           : freq;
  end
  // State, outputs and tick/duration counters; counters restart on every state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      note_idx <= '0;
      freq <= '0;
      onOff <= 1'b0;
      tcnt <= '0;
      dcnt <= '0;
      dur_last <= '0;
    end else begin
      state <= state_n;
      note_idx <= idx_n;
      freq <= freq_n;
      onOff <= on_n;
      tcnt <= (adv || tick || state == IDLE) ? '0 : tcnt + 32'd1;
      dcnt <= (adv || state == IDLE) ? '0 : dcnt + 8'(tick);
      if (adv) dur_last <= (nxt.dur == 8'd0) ? 8'd0 : nxt.dur - 8'd1;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench; stimulus queues timed output changes, a monitor checks each change
module tb_note_sequencer;
  localparam int BIG = 32'h7fff_ffff;
  localparam int MEL_F [8] = '{262, 330, 392, 0, 523, 392, 330, 262};
  localparam int MEL_D [8] = '{4, 4, 4, 2, 8, 2, 2, 8};
  typedef struct packed {
    logic [31:0] f;
    logic        on;
    logic [2:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;
  typedef struct {
    int   t;
    obs_t v;
  } exp_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [31:0] freq;
  logic onOff, busy, done;
  logic [2:0] note_idx;
  obs_t cur, prev, last;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0, t0;
  bit mon_en = 1'b0;
  note_sequencer #(.FCLK(1000), .TICK_HZ(100), .GAP_TICKS(2), .NUM_NOTES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .freq(freq), .onOff(onOff), .busy(busy), .note_idx(note_idx), .done(done)
  );
  assign cur = {freq, onOff, note_idx, busy, done};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic obs_t mk(input logic [31:0] f, input logic on, input logic [2:0] idx,
                              input logic b, input logic d);
    mk = {f, on, idx, b, d};
  endfunction
  task automatic push(input int t, input obs_t v, input int cutoff);
    exp_t e;
    if (t < cutoff && v != last) begin
      e.t = t;
      e.v = v;
      q.push_back(e);
      last = v;
    end
  endtask
  task automatic push_pass(input int ts, input bit fin, input int cutoff);
    int t = ts;
    logic [31:0] f = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (MEL_F[k] != 0) f = MEL_F[k];
      push(t, mk(f, MEL_F[k] != 0, 3'(k), 1'b1, 1'b0), cutoff);
      t += MEL_D[k] * 10;
      push(t, mk(f, 1'b0, 3'(k), 1'b1, 1'b0), cutoff);
      t += 20;
    end
    if (fin) begin
      push(t, mk(0, 1'b0, 3'd0, 1'b0, 1'b1), cutoff);
      push(t + 1, mk(0, 1'b0, 3'd0, 1'b0, 1'b0), cutoff);
    end
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got f=%0d on=%0b idx=%0d busy=%0b done=%0b expected no change",
                   cyc, cur.f, cur.on, cur.idx, cur.busy, cur.done);
        end else begin
          e = q.pop_front();
          if (e.t != cyc || e.v !== cur) begin
            fails++;
            $display("FAIL event got cyc=%0d f=%0d on=%0b idx=%0d busy=%0b done=%0b expected cyc=%0d f=%0d on=%0b idx=%0d busy=%0b done=%0b",
                     cyc, cur.f, cur.on, cur.idx, cur.busy, cur.done,
                     e.t, e.v.f, e.v.on, e.v.idx, e.v.busy, e.v.done);
          end
        end
      end
      prev = cur;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_freq", freq, 0);
    check("rst_onOff", 32'(onOff), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(note_idx), 0);
    check("rst_done", 32'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);
    prev = cur;
    last = '0;
    mon_en = 1'b1;
    t0 = cyc + 1;
    push_pass(t0, 1'b1, BIG);
    pulse_start();
    wait_until(t0 + 25);
    pulse_start();
    wait_until(t0 + 185);
    pulse_start();
    wait_until(t0 + 510);
    check("basic_idle_busy", 32'(busy), 0);
    loop = 1'b1;
    t0 = cyc + 1;
    push_pass(t0, 1'b0, BIG);
    push_pass(t0 + 500, 1'b1, BIG);
    pulse_start();
    wait_until(t0 + 550);
    loop = 1'b0;
    wait_until(t0 + 1010);
    check("loop_end_busy", 32'(busy), 0);
    t0 = cyc + 1;
    push_pass(t0, 1'b1, t0 + 131);
    push(t0 + 131, mk(0, 1'b0, 3'd0, 1'b0, 1'b0), BIG);
    pulse_start();
    wait_until(t0 + 130);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_until(t0 + 140);
    check("stop_busy", 32'(busy), 0);
    check("stop_freq", freq, 0);
    check("stop_onOff", 32'(onOff), 0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (30) @(negedge clk);
    check("start_stop_busy", 32'(busy), 0);
    check("start_stop_onOff", 32'(onOff), 0);
    t0 = cyc + 1;
    push_pass(t0, 1'b1, t0 + 105);
    pulse_start();
    wait_until(t0 + 106);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_freq", freq, 0);
    check("arst_onOff", 32'(onOff), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_idx", 32'(note_idx), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    prev = cur;
    last = '0;
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_freq", freq, 0);
    check("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
